// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader.
// Holds the memory geometry, the 8-bit instruction encoding (opcodes,
// field positions, the NOP fill word) and the loader FSM state type.
package imem_pkg;

  localparam int DEPTH = 32;  // instruction words held
  localparam int PTR_W = 6;   // holds 0..DEPTH

  // Opcodes, instruction bits [7:6]
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  // Field positions inside an instruction byte {op,rs,rt,imm}
  localparam int OP_HI  = 7;
  localparam int OP_LO  = 6;
  localparam int RS_HI  = 5;
  localparam int RS_LO  = 4;
  localparam int RT_HI  = 3;
  localparam int RT_LO  = 2;
  localparam int IMM_HI = 1;
  localparam int IMM_LO = 0;

  // Jump-to-0 style word used for cleared or absent locations
  localparam logic [7:0] NOP_WORD = {OP_J, 2'b00, 2'b00, 2'b00};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  function automatic logic [1:0] instr_op(input logic [7:0] w);
    return w[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Program byte stream into the loader.
// Handshake: a byte moves on a rising edge where in_valid and in_ready are
// both 1. The source holds in_data/in_last stable while in_valid is high and
// in_ready is low; in_last marks the final byte of a program.
//   master: program source (drives in_valid, in_data, in_last)
//   slave : loader         (drives in_ready)
interface imem_loader_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/imem_ram.sv
// DEPTH x 8 instruction storage.
// Ports: clk_i, rst_n_i (sync, active-low, fills NOP), clr_i (sync fill NOP),
//        we_i/waddr_i/wdata_i (sync write), raddr_i -> rdata_o (async read).
// A read of the address being written returns the old word.
module imem_ram
  import imem_pkg::*;
#(
  parameter int         RAM_DEPTH = DEPTH,
  parameter int         ADDR_W    = PTR_W - 1,
  parameter logic [7:0] FILL      = NOP_WORD
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [RAM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clr_i) begin
      for (int i = 0; i < RAM_DEPTH; i++) mem_q[i] <= FILL;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_loader.sv
// Writer side of the CPU instruction memory.
// Loads a program from a byte stream into imem_ram and keeps the CPU held
// (cpu_run=0) until the load finishes, either on in_last or when the memory
// is full (trunc=1). The CPU read port behaves like a ROM: combinational,
// NOP_WORD outside the memory or while a load is in progress.
// Ports: clk50, reset (sync active-low), load_start, in_if (stream slave),
//        rd_addr/rd_data (CPU fetch), cpu_run, busy, load_count, trunc,
//        dbg_state (current FSM state).
module imem_loader
  import imem_pkg::*;
(
  input  logic             clk50,
  input  logic             reset,
  input  logic             load_start,
  imem_loader_if.slave     in_if,
  input  logic [7:0]       rd_addr,
  output logic [7:0]       rd_data,
  output logic             cpu_run,
  output logic             busy,
  output logic [PTR_W-1:0] load_count,
  output logic             trunc,
  output state_t           dbg_state
);

  localparam logic [7:0]       DEPTH_A   = 8'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH - 1);

  state_t           state_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] load_count_q;
  logic             trunc_q;
  logic             cpu_run_q;
  logic             busy_q;
  logic             in_ready_q;

  logic       xfer;
  logic       start_ok;
  logic [7:0] ram_rdata;

  assign xfer     = in_if.in_valid & in_ready_q;
  // load_start is only honoured outside LOAD
  assign start_ok = load_start & (state_q != ST_LOAD);

  always_ff @(posedge clk50) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      load_count_q <= '0;
      trunc_q      <= 1'b0;
      cpu_run_q    <= 1'b0;
      busy_q       <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_RUN: begin
          if (start_ok) begin
            state_q      <= ST_LOAD;
            wr_ptr_q     <= '0;
            load_count_q <= '0;
            trunc_q      <= 1'b0;
            cpu_run_q    <= 1'b0;
            busy_q       <= 1'b1;
            in_ready_q   <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            wr_ptr_q     <= wr_ptr_q + 1'b1;
            load_count_q <= load_count_q + 1'b1;
            // Finish on the tagged last byte or when the final slot fills
            if (in_if.in_last || wr_ptr_q == LAST_SLOT) begin
              state_q    <= ST_RUN;
              trunc_q    <= ~in_if.in_last;
              cpu_run_q  <= 1'b1;
              busy_q     <= 1'b0;
              in_ready_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          cpu_run_q  <= 1'b0;
          busy_q     <= 1'b0;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  imem_ram #(
    .RAM_DEPTH (DEPTH),
    .ADDR_W    (PTR_W - 1),
    .FILL      (NOP_WORD)
  ) u_ram (
    .clk_i   (clk50),
    .rst_n_i (reset),
    .clr_i   (start_ok),
    .we_i    (xfer),
    .waddr_i (wr_ptr_q[PTR_W-2:0]),
    .wdata_i (in_if.in_data),
    .raddr_i (rd_addr[PTR_W-2:0]),
    .rdata_o (ram_rdata)
  );

  assign rd_data = (rd_addr < DEPTH_A && state_q != ST_LOAD) ? ram_rdata : NOP_WORD;

  assign in_if.in_ready = in_ready_q;
  assign cpu_run        = cpu_run_q;
  assign busy           = busy_q;
  assign load_count     = load_count_q;
  assign trunc          = trunc_q;
  assign dbg_state      = state_q;

endmodule
